// File: rtl/text_ram_port_sched_if.sv
// CPU-side request/acknowledge bus for the text RAM port-B scheduler.
// The CPU drives the request fields; the scheduler returns ack and read data.
interface text_ram_port_sched_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata
   );
endinterface

// File: rtl/text_ram_port_sched.sv
// Shares port B of the text character RAM between the CPU bus and a screen-clear
// engine; one registered port-B operation per cycle, with CPU requests taking priority.
module text_ram_port_sched #(
   parameter int AW        = 12,
   parameter int DW        = 32,
   parameter int CLR_WORDS = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   text_ram_port_sched_if.slave   cpu,
   input  logic                   clr_start,
   input  logic [DW-1:0]          clr_value,
   output logic                   clr_busy,
   output logic                   clr_done,
   output logic [AW-1:0]          addr_b,
   output logic [DW-1:0]          data_b,
   output logic                   we_b,
   input  logic [DW-1:0]          q_b
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [AW:0] LAST = (AW+1)'(CLR_WORDS - 1);

   state_t        state, state_n;
   logic [AW:0]   cnt, cnt_n;
   logic [DW-1:0] fill, fill_n;
   logic          wr_ack, rd_s1, rd_s2;
   logic          cpu_grant;
   logic          clr_issue, clr_last;
   logic [AW-1:0] clr_addr;
   logic [DW-1:0] clr_data;

   // An accepted clear with no competing CPU grant writes word 0 in the accept slot itself.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      fill_n    = fill;
      clr_issue = 1'b0;
      clr_last  = 1'b0;
      clr_addr  = cnt[AW-1:0];
      clr_data  = fill;
      cpu_grant = cpu.cpu_req && !(wr_ack || rd_s1 || rd_s2);
      case (state)
         IDLE: begin
            if (clr_start) begin
               fill_n  = clr_value;
               cnt_n   = '0;
               state_n = CLEAR;
               if (!cpu_grant) begin
                  clr_issue = 1'b1;
                  clr_addr  = '0;
                  clr_data  = clr_value;
                  cnt_n     = (AW+1)'(1);
                  clr_last  = (LAST == '0);
                  if (clr_last) state_n = IDLE;
               end
            end
         end
         CLEAR: begin
            if (!cpu_grant) begin
               clr_issue = 1'b1;
               cnt_n     = cnt + 1'b1;
               clr_last  = (cnt == LAST);
               if (clr_last) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         fill     <= '0;
         we_b     <= 1'b0;
         addr_b   <= '0;
         data_b   <= '0;
         wr_ack   <= 1'b0;
         rd_s1    <= 1'b0;
         rd_s2    <= 1'b0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         fill     <= fill_n;
         wr_ack   <= cpu_grant && cpu.cpu_we;
         rd_s1    <= cpu_grant && !cpu.cpu_we;
         rd_s2    <= rd_s1;
         clr_done <= clr_last;
         clr_busy <= (state_n == CLEAR) || clr_last;
         we_b     <= cpu_grant ? cpu.cpu_we : clr_issue;
         if (cpu_grant) begin
            addr_b <= cpu.cpu_addr;
            if (cpu.cpu_we) data_b <= cpu.cpu_wdata;
         end else if (clr_issue) begin
            addr_b <= clr_addr;
            data_b <= clr_data;
         end
      end
   end

   // The read tag marks the q_b cycle that belongs to a CPU read; clear writes never set it.
   assign cpu.cpu_ack   = wr_ack || rd_s2;
   assign cpu.cpu_rdata = rd_s2 ? q_b : '0;

endmodule

// File: tb/tb_text_ram_port_sched.sv
// Self-checking bench for text_ram_port_sched: a behavioural RAM on port B plus an
// expected-memory scoreboard and spec-derived timing for acks and clear progress.
module tb_text_ram_port_sched;
   localparam int AW        = 12;
   localparam int DW        = 32;
   localparam int CLR_WORDS = 16;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          clr_start = 1'b0;
   logic [DW-1:0] clr_value = '0;
   logic          clr_busy, clr_done, we_b;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] data_b;
   logic [DW-1:0] q_b = '0;

   logic [DW-1:0] mem     [0:4095] = '{default: '0};
   logic [DW-1:0] exp_mem [0:4095] = '{default: '0};
   logic [AW-1:0] written [$];

   int checks = 0;
   int errors = 0;

   text_ram_port_sched_if #(.AW(AW), .DW(DW)) bus ();

   text_ram_port_sched #(.AW(AW), .DW(DW), .CLR_WORDS(CLR_WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (bus),
      .clr_start (clr_start),
      .clr_value (clr_value),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .addr_b    (addr_b),
      .data_b    (data_b),
      .we_b      (we_b),
      .q_b       (q_b)
   );

   always #10 clk = ~clk;

   // Port-B RAM: one-cycle registered read with write-through.
   always @(posedge clk) begin
      if (we_b) begin
         mem[addr_b] <= data_b;
         q_b         <= data_b;
      end else begin
         q_b <= mem[addr_b];
      end
   end

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; bus.cpu_req = 1'b0; clr_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (we_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_we_b: got %b expected 0", we_b); end
      checks++; if (addr_b !== '0) begin errors++; $display("[TB] FAIL reset_addr_b: got %h expected 0", addr_b); end
      checks++; if (data_b !== '0) begin errors++; $display("[TB] FAIL reset_data_b: got %h expected 0", data_b); end
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.cpu_ack); end
      checks++; if (bus.cpu_rdata !== '0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.cpu_rdata); end
      checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr: got busy %b done %b expected 0 0", clr_busy, clr_done); end
      rst = 1'b0;
   endtask

   task automatic test_cpu_write();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? 12'h005 : AW'($urandom_range(16, 4095));
         d = (i == 0) ? 32'hDEADBEEF : $urandom;
         @(negedge clk);
         bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
         @(negedge clk);
         checks++;
         if (we_b !== 1'b1 || addr_b !== a || data_b !== d) begin
            errors++; $display("[TB] FAIL write_port: got we %b addr %h data %h expected 1 %h %h", we_b, addr_b, data_b, a, d);
         end
         checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL write_ack: got %b expected 1", bus.cpu_ack); end
         bus.cpu_req = 1'b0;
         @(negedge clk);
         checks++;
         if (we_b !== 1'b0 || bus.cpu_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL write_after: got we %b ack %b expected 0 0", we_b, bus.cpu_ack);
         end
         exp_mem[a] = d;
         written.push_back(a);
      end
   endtask

   task automatic test_cpu_read();
      logic [AW-1:0] a;
      for (int i = 0; i < 6; i++) begin
         a = (i == 0) ? 12'h005 : written[$urandom_range(0, written.size() - 1)];
         @(negedge clk);
         bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
         @(negedge clk);
         checks++;
         if (we_b !== 1'b0 || addr_b !== a || bus.cpu_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL read_port: got we %b addr %h ack %b expected 0 %h 0", we_b, addr_b, bus.cpu_ack, a);
         end
         @(negedge clk);
         checks++;
         if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== exp_mem[a]) begin
            errors++; $display("[TB] FAIL read_data: got ack %b data %h expected 1 %h", bus.cpu_ack, bus.cpu_rdata, exp_mem[a]);
         end
         bus.cpu_req = 1'b0;
         @(negedge clk);
         checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL read_single_ack: got %b expected 0", bus.cpu_ack); end
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] wa [4];
      logic [DW-1:0] wd [4];
      int idx;
      for (int j = 0; j < 4; j++) begin
         wa[j] = AW'(12'h200 + j);
         wd[j] = $urandom;
      end
      idx = 0;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = wa[0]; bus.cpu_wdata = wd[0];
      for (int k = 1; k <= 30 && idx < 4; k++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin
            checks++; if (k != 1 + 2 * idx) begin errors++; $display("[TB] FAIL b2b_write_cycle: got %0d expected %0d", k, 1 + 2 * idx); end
            exp_mem[wa[idx]] = wd[idx];
            idx++;
            if (idx < 4) begin bus.cpu_addr = wa[idx]; bus.cpu_wdata = wd[idx]; end
            else bus.cpu_req = 1'b0;
         end
      end
      checks++; if (idx != 4) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d expected 4", idx); end
      bus.cpu_req = 1'b0;
      idx = 0;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = wa[0];
      for (int k = 1; k <= 30 && idx < 4; k++) begin
         @(negedge clk);
         if (bus.cpu_ack) begin
            checks++;
            if (k != 2 + 3 * idx || bus.cpu_rdata !== wd[idx]) begin
               errors++; $display("[TB] FAIL b2b_read: got cycle %0d data %h expected %0d %h", k, bus.cpu_rdata, 2 + 3 * idx, wd[idx]);
            end
            idx++;
            if (idx < 4) bus.cpu_addr = wa[idx];
            else bus.cpu_req = 1'b0;
         end
      end
      checks++; if (idx != 4) begin errors++; $display("[TB] FAIL b2b_read_count: got %0d expected 4", idx); end
      bus.cpu_req = 1'b0;
   endtask

   task automatic test_clear_idle();
      int nwr, ndone, done_k, busy_n, first_busy;
      nwr = 0; ndone = 0; done_k = -1; busy_n = 0; first_busy = -1;
      @(negedge clk);
      clr_start = 1'b1; clr_value = 32'h0000_0020;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (we_b) begin
            checks++;
            if (addr_b !== AW'(nwr) || data_b !== 32'h20) begin
               errors++; $display("[TB] FAIL clr_write: got addr %h data %h expected %h 00000020", addr_b, data_b, AW'(nwr));
            end
            nwr++;
         end
         if (clr_done) begin
            ndone++; done_k = k;
            checks++;
            if (we_b !== 1'b1 || addr_b !== AW'(CLR_WORDS - 1)) begin
               errors++; $display("[TB] FAIL clr_done_addr: got we %b addr %h expected 1 %h", we_b, addr_b, AW'(CLR_WORDS - 1));
            end
         end
         if (clr_busy) begin
            busy_n++;
            if (first_busy < 0) first_busy = k;
         end
      end
      checks++; if (nwr != CLR_WORDS) begin errors++; $display("[TB] FAIL clr_count: got %0d expected %0d", nwr, CLR_WORDS); end
      checks++; if (ndone != 1 || done_k != CLR_WORDS) begin errors++; $display("[TB] FAIL clr_done_cycle: got %0d pulses at %0d expected 1 at %0d", ndone, done_k, CLR_WORDS); end
      checks++; if (busy_n != CLR_WORDS || first_busy != 1) begin errors++; $display("[TB] FAIL clr_busy_len: got %0d from %0d expected %0d from 1", busy_n, first_busy, CLR_WORDS); end
      for (int w = 0; w < CLR_WORDS; w++) begin
         exp_mem[w] = 32'h20;
         checks++; if (mem[w] !== 32'h20) begin errors++; $display("[TB] FAIL clr_readback[%0d]: got %h expected 00000020", w, mem[w]); end
      end
   endtask

   task automatic test_clear_with_cpu();
      logic [DW-1:0] f;
      logic [DW-1:0] d [4];
      logic [15:0]   seen;
      int nclr, ncpu, stray, consec, done_k, ndone, idx;
      logic prev_cpu;
      f = $urandom;
      for (int j = 0; j < 4; j++) d[j] = $urandom;
      seen = '0; nclr = 0; ncpu = 0; stray = 0; consec = 0; done_k = -1; ndone = 0; idx = 0; prev_cpu = 1'b0;
      @(negedge clk);
      clr_start = 1'b1; clr_value = f;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h100; bus.cpu_wdata = d[0];
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (we_b && addr_b >= 12'h100) begin
            checks++;
            if (ncpu >= 4 || addr_b !== AW'(12'h100 + ncpu) || data_b !== d[ncpu & 3]) begin
               errors++; $display("[TB] FAIL mix_cpu_write: got addr %h data %h expected %h %h", addr_b, data_b, AW'(12'h100 + ncpu), d[ncpu & 3]);
            end
            if (prev_cpu) consec++;
            prev_cpu = 1'b1;
            ncpu++;
         end else if (we_b) begin
            if (addr_b >= AW'(CLR_WORDS) || seen[addr_b[3:0]]) stray++;
            else seen[addr_b[3:0]] = 1'b1;
            checks++; if (data_b !== f) begin errors++; $display("[TB] FAIL mix_clr_data: got %h expected %h", data_b, f); end
            nclr++;
            prev_cpu = 1'b0;
         end else begin
            prev_cpu = 1'b0;
         end
         if (clr_done) begin ndone++; done_k = k; end
         if (bus.cpu_ack) begin
            idx++;
            if (idx < 4) begin bus.cpu_addr = AW'(12'h100 + idx); bus.cpu_wdata = d[idx]; end
            else bus.cpu_req = 1'b0;
         end
      end
      bus.cpu_req = 1'b0;
      checks++; if (nclr != CLR_WORDS || stray != 0) begin errors++; $display("[TB] FAIL mix_clr_count: got %0d writes %0d stray expected %0d 0", nclr, stray, CLR_WORDS); end
      checks++; if (ncpu != 4 || consec != 0) begin errors++; $display("[TB] FAIL mix_cpu_count: got %0d writes %0d adjacent expected 4 0", ncpu, consec); end
      checks++; if (ndone != 1 || done_k != CLR_WORDS + 4) begin errors++; $display("[TB] FAIL mix_done_cycle: got %0d at %0d expected 1 at %0d", ndone, done_k, CLR_WORDS + 4); end
      for (int w = 0; w < CLR_WORDS; w++) exp_mem[w] = f;
      for (int j = 0; j < 4; j++) exp_mem[12'h100 + j] = d[j];
      for (int w = 0; w < CLR_WORDS; w++) begin
         checks++; if (mem[w] !== exp_mem[w]) begin errors++; $display("[TB] FAIL mix_readback[%0d]: got %h expected %h", w, mem[w], exp_mem[w]); end
      end
      for (int j = 0; j < 4; j++) begin
         checks++; if (mem[12'h100 + j] !== d[j]) begin errors++; $display("[TB] FAIL mix_cpu_readback[%0d]: got %h expected %h", j, mem[12'h100 + j], d[j]); end
      end
   endtask

   task automatic test_read_during_clear();
      logic [DW-1:0] f;
      int acks, ack_k, ndone;
      logic got;
      got = 1'b0;
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h003; bus.cpu_wdata = 32'h12345678;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (bus.cpu_ack) got = 1'b1;
      end
      bus.cpu_req = 1'b0;
      checks++; if (!got) begin errors++; $display("[TB] FAIL preload_ack: got none expected 1"); end
      f = $urandom;
      if (f == 32'h12345678) f = ~f;
      acks = 0; ack_k = -1; ndone = 0;
      @(negedge clk);
      clr_start = 1'b1; clr_value = f;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h003;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (bus.cpu_ack) begin
            acks++; ack_k = k;
            checks++; if (bus.cpu_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL rdc_data: got %h expected 12345678", bus.cpu_rdata); end
            bus.cpu_req = 1'b0;
         end
         if (clr_done) ndone++;
      end
      bus.cpu_req = 1'b0;
      checks++; if (acks != 1 || ack_k != 2) begin errors++; $display("[TB] FAIL rdc_acks: got %0d at %0d expected 1 at 2", acks, ack_k); end
      checks++; if (ndone != 1 || mem[3] !== f) begin errors++; $display("[TB] FAIL rdc_clear: got done %0d word3 %h expected 1 %h", ndone, mem[3], f); end
      for (int w = 0; w < CLR_WORDS; w++) exp_mem[w] = f;
   endtask

   task automatic test_reset_mid_clear();
      logic [DW-1:0] f, g;
      logic found;
      int nwr, order_err, ndone;
      f = $urandom; found = 1'b0;
      @(negedge clk);
      clr_start = 1'b1; clr_value = f;
      for (int k = 1; k <= 20 && !found; k++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (we_b && addr_b == 12'h006) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("[TB] FAIL rmc_find_addr6: got none expected addr 006"); end
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h050;
      @(negedge clk);
      checks++; if (we_b !== 1'b0 || addr_b !== 12'h050) begin errors++; $display("[TB] FAIL rmc_read_port: got we %b addr %h expected 0 050", we_b, addr_b); end
      @(negedge clk);
      checks++; if (we_b !== 1'b1 || addr_b !== 12'h007) begin errors++; $display("[TB] FAIL rmc_addr7: got we %b addr %h expected 1 007", we_b, addr_b); end
      rst = 1'b1; bus.cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (we_b !== 1'b0 || clr_busy !== 1'b0 || bus.cpu_ack !== 1'b0 || clr_done !== 1'b0) begin
         errors++; $display("[TB] FAIL rmc_after_rst: got we %b busy %b ack %b done %b expected 0 0 0 0", we_b, clr_busy, bus.cpu_ack, clr_done);
      end
      @(negedge clk);
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL rmc_no_ack: got %b expected 0", bus.cpu_ack); end
      // A read whose q_b cycle is cut off by reset must never be acknowledged.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h005;
      @(negedge clk);
      checks++; if (we_b !== 1'b0 || addr_b !== 12'h005) begin errors++; $display("[TB] FAIL drop_read_port: got we %b addr %h expected 0 005", we_b, addr_b); end
      rst = 1'b1; bus.cpu_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL drop_ack0: got %b expected 0", bus.cpu_ack); end
      @(negedge clk);
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL drop_ack1: got %b expected 0", bus.cpu_ack); end
      g = $urandom; nwr = 0; order_err = 0; ndone = 0;
      clr_start = 1'b1; clr_value = g;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (we_b) begin
            if (addr_b !== AW'(nwr) || data_b !== g) order_err++;
            nwr++;
         end
         if (clr_done) ndone++;
      end
      checks++; if (nwr != CLR_WORDS || order_err != 0 || ndone != 1) begin errors++; $display("[TB] FAIL restart: got %0d writes %0d out of order %0d done expected %0d 0 1", nwr, order_err, ndone, CLR_WORDS); end
      for (int w = 0; w < CLR_WORDS; w++) begin
         exp_mem[w] = g;
         checks++; if (mem[w] !== g) begin errors++; $display("[TB] FAIL restart_readback[%0d]: got %h expected %h", w, mem[w], g); end
      end
   endtask

   initial begin
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_back_to_back();
      test_clear_idle();
      test_clear_with_cpu();
      test_read_during_clear();
      test_reset_mid_clear();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/text_ram_port_sched.md
Name: text_ram_port_sched

Overview:
- Owns port B of the 4096x32 text character RAM (1-cycle registered read, write-through q_b) and shares it between two users: the CPU bus and a built-in screen-clear engine.
- The clear engine fills a range of words with a fill value.
- Issues at most one port-B operation per cycle, all registered; the VGA side (port A) is untouched.

Parameters:
- AW, 12, RAM address width.
- DW, 32, RAM data width.
- CLR_WORDS, 4096, number of words written by one clear, addresses 0..CLR_WORDS-1; legal range 1..2^AW.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU request; held high with fields stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data, valid only while cpu_ack is high after a read.
- clr_start  in  1  start-clear pulse.
- clr_value  in  DW  fill word, sampled with clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse on the last clear write.
- addr_b  out  AW  RAM port-B address (registered).
- data_b  out  DW  RAM port-B write data (registered).
- we_b  out  1  RAM port-B write enable (registered).
- q_b  in  DW  RAM port-B read data, valid 1 cycle after addr_b.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - we_b, addr_b, data_b, cpu_ack, clr_busy, clr_done = 0; cpu_rdata = 0.
  - State goes to IDLE; clear counter and pending flags are cleared.
  - Any in-flight read is dropped: no ack follows reset.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clr_start: latch clr_value, clear counter = 0.
  - CLEAR -> IDLE in the cycle after the last clear write is issued.
  - clr_start while in CLEAR is ignored.
- Slot decision is made in cycle t; the resulting op is on addr_b/data_b/we_b in cycle t+1.
  - In a slot with no op: we_b = 0; addr_b and data_b hold their previous values.
- CPU eligibility: cpu_req high and no CPU op outstanding.
  - A write is outstanding through its ack cycle.
  - A read is outstanding through its ack cycle.
- Arbitration: an eligible CPU request has priority over the clear engine. The CPU is ineligible in the slot after any grant, so clear gets at least every other slot (no starvation either way).
- CPU write granted at t:
  - t+1: we_b = 1, addr_b = cpu_addr, data_b = cpu_wdata, cpu_ack = 1.
- CPU read granted at t:
  - t+1: we_b = 0, addr_b = cpu_addr.
  - t+2: cpu_ack = 1, cpu_rdata = q_b (combinational pass-through).
  - Clear writes issued in t+1 or t+2 never produce an ack or alter cpu_rdata. A 2-stage read tag tracks which q_b belongs to the CPU.
- Throughput: CPU back-to-back writes, one per 2 cycles; reads, one per 3 cycles.
- CLEAR slot:
  - If the CPU does not win, issue we_b = 1, addr_b = counter, data_b = latched value, then counter++.
  - The write with counter = CLR_WORDS-1 asserts clr_done in its port cycle.
- clr_busy: high from the cycle after clr_start is accepted through the clr_done cycle inclusive; low afterwards.
- clr_start together with cpu_req in IDLE: the CPU is granted the slot and the clear is still accepted. The first clear write lands on the next free slot.
- Counter width is AW+1, so CLR_WORDS = 2^AW does not wrap early; addresses never exceed CLR_WORDS-1.
- A CPU write to an address not yet cleared is overwritten later by the clear. This is intended; the CPU waits on clr_busy if ordering matters.

Test Plan:
- Reset, then CPU write addr 0x005, data 0xDEADBEEF, req at cycle 0 -> cycle 1: we_b = 1, addr_b = 0x005, data_b = 0xDEADBEEF, cpu_ack = 1; cycle 2: we_b = 0.
- CPU read 0x005, req at cycle 0 -> cycle 1: addr_b = 0x005, we_b = 0; cycle 2: cpu_ack = 1, cpu_rdata = 0xDEADBEEF; no ack in cycle 1.
- CLR_WORDS = 16, clr_start with clr_value = 0x00000020, no CPU traffic -> 16 consecutive writes to addr 0..15.
  - clr_done on addr 15.
  - clr_busy high for exactly 16 cycles.
  - Port-A readback of all 16 words = 0x20.
- Same clear with the CPU writing 0x100..0x103 continuously from clear start -> port ops alternate clear/CPU.
  - All 16 clear writes and 4 CPU writes occur; none lost or duplicated.
  - clr_done is 4 cycles later than the previous scenario.
- CPU read of addr 3 (preloaded 0x12345678) during clear, issued before the clear reaches addr 3 -> cpu_rdata = 0x12345678, not the fill value; exactly one ack.
- rst at the clock where clear addr 7 is on the port, with a CPU read outstanding -> next cycle we_b = 0, clr_busy = 0, no cpu_ack. A following clr_start restarts the clear from addr 0.
